// File: rtl/return_addr_stack_pkg.sv
// Shared y86 instruction-code constants used by the fetch/write-back
// predictor logic.
package return_addr_stack_pkg;

    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

endpackage

// File: rtl/return_addr_stack_ras_regfile.sv
// ras_regfile: DEPTH x WIDTH storage for the return-address stack.
// Ports:
//   clk    - clock, write on rising edge
//   wrEn   - write enable
//   wrAddr - write address
//   wrData - write data
//   rdAddr - asynchronous read address
//   rdData - asynchronous read data
// Contents are deliberately not reset.
module ras_regfile #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: speculative return-address predictor for the y86
// pipeline. A speculative pointer/count pair tracks CALL/RET in fetch; a
// committed pair tracks CALL/RET retiring in write-back. A mispredict flush
// rewinds the speculative pair to the committed one (including this cycle's
// commit). Stack entries overwritten on a wrong path are not restored.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   f_icode_i/f_valP_i/f_adv_i - fetch-stage icode, fall-through PC, advance
//   flush_i           - mispredict squash
//   W_icode_i/W_stall_i - write-back icode and stall
//   f_ret_pred_o/f_ret_valid_o - predicted RET target and its validity
//   ras_ovf_cnt_o/ras_unf_cnt_o - overflow/underflow event counters
//                       (only when RAS_STATS_EN is defined)
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       f_icode_i,
    input  logic [WIDTH-1:0] f_valP_i,
    input  logic             f_adv_i,
    input  logic             flush_i,
    input  logic [3:0]       W_icode_i,
    input  logic             W_stall_i,
`ifdef RAS_STATS_EN
    output logic [31:0]      ras_ovf_cnt_o,
    output logic [31:0]      ras_unf_cnt_o,
`endif
    output logic [WIDTH-1:0] f_ret_pred_o,
    output logic             f_ret_valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] sp, csp, cspNext, rdAddr;
    logic [PTR_W:0]   cnt, ccnt, ccntNext;
    logic [WIDTH-1:0] rdData;
    logic             specPush, specPop, commitCall, commitRet;

    assign specPush   = f_adv_i & (f_icode_i == ICALL) & ~flush_i;
    assign specPop    = f_adv_i & (f_icode_i == IRET)  & ~flush_i;
    assign commitCall = ~W_stall_i & (W_icode_i == ICALL);
    assign commitRet  = ~W_stall_i & (W_icode_i == IRET);

    // Committed state for next cycle; flush must see this cycle's commit.
    always_comb begin
        cspNext  = csp;
        ccntNext = ccnt;
        if (commitCall) begin
            cspNext = csp + 1'b1;
            if (ccnt != FULL) begin
                ccntNext = ccnt + 1'b1;
            end
        end else if (commitRet && (ccnt != '0)) begin
            cspNext  = csp - 1'b1;
            ccntNext = ccnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sp   <= '0;
            cnt  <= '0;
            csp  <= '0;
            ccnt <= '0;
        end else begin
            csp  <= cspNext;
            ccnt <= ccntNext;
            if (flush_i) begin
                sp  <= cspNext;
                cnt <= ccntNext;
            end else if (specPush) begin
                sp <= sp + 1'b1;
                if (cnt != FULL) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (specPop && (cnt != '0)) begin
                sp  <= sp - 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef RAS_STATS_EN
    logic [31:0] ovfCnt, unfCnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovfCnt <= '0;
            unfCnt <= '0;
        end else begin
            if (specPush && (cnt == FULL)) begin
                ovfCnt <= ovfCnt + 1'b1;
            end
            if (specPop && (cnt == '0)) begin
                unfCnt <= unfCnt + 1'b1;
            end
        end
    end

    assign ras_ovf_cnt_o = ovfCnt;
    assign ras_unf_cnt_o = unfCnt;
`endif

    assign rdAddr = sp - 1'b1;

    ras_regfile #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_regfile (
        .clk    (clk_i),
        .wrEn   (specPush & ~rst_i),
        .wrAddr (sp),
        .wrData (f_valP_i),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    assign f_ret_valid_o = (cnt != '0);
    assign f_ret_pred_o  = (cnt != '0) ? rdData : '0;

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 Parameter: DEPTH, 8, number of stack entries (power of two, 2..32).
REQ-002 Parameter: WIDTH, 64, return-address width in bits.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 f_icode_i  in  4  icode of the instruction in fetch.
REQ-006 f_valP_i  in  WIDTH  fall-through PC of the instruction in fetch.
REQ-007 f_adv_i  in  1  the fetch instruction enters D this cycle (not stalled, not bubbled).
REQ-008 flush_i  in  1  wrong-path squash from a branch mispredict.
REQ-009 W_icode_i  in  4  icode of the instruction in write-back.
REQ-010 W_stall_i  in  1  write-back stalled; no commit this cycle.
REQ-011 f_ret_pred_o  out  WIDTH  predicted return target for a RET in fetch.
REQ-012 f_ret_valid_o  out  1  f_ret_pred_o is meaningful (speculative count nonzero).

Function
REQ-013 The block SHALL hold a circular array mem[DEPTH], a speculative pointer sp and count cnt, and a committed pointer csp and count ccnt (pointers log2(DEPTH) bits, counts 0..DEPTH).
REQ-014 f_ret_pred_o SHALL be mem[sp-1 mod DEPTH] when cnt>0 and 0 when cnt==0; f_ret_valid_o SHALL equal (cnt!=0); both are combinational from registered state (0-cycle latency).
REQ-015 Speculative push: f_adv_i & f_icode_i==ICALL & ~flush_i SHALL write mem[sp]<=f_valP_i, sp<=sp+1 (wrap), cnt<=min(cnt+1,DEPTH).
REQ-016 Speculative pop: f_adv_i & f_icode_i==IRET & ~flush_i SHALL set sp<=sp-1 (wrap), cnt<=cnt-1 if cnt>0; with cnt==0 sp and cnt SHALL stay unchanged.
REQ-017 Overflow: push at cnt==DEPTH SHALL overwrite the oldest entry, advance sp, and hold cnt at DEPTH.
REQ-018 Commit: ~W_stall_i & W_icode_i==ICALL SHALL advance csp/ccnt with the same wrap/saturation rules; W_icode_i==IRET SHALL retreat them with the same floor-at-0 rule; mem is not written by commit.
REQ-019 Flush: flush_i SHALL set sp<=csp_next and cnt<=ccnt_next, where *_next includes the commit of the same cycle; flush overrides any speculative push/pop that cycle.
REQ-020 Entries overwritten on the wrong path are not restored; the block is a predictor only, and select_pc correction via W_valM keeps architectural behaviour exact.
REQ-021 Any icode other than ICALL/IRET, or f_adv_i==0, SHALL leave speculative state unchanged.

Reset
REQ-022 rst_i SHALL clear sp, cnt, csp, ccnt and stats counters to 0 on the next rising edge, overriding push/pop/commit/flush; mem is not reset.
REQ-023 During and after reset f_ret_valid_o==0 and f_ret_pred_o==0 until the first push.

Configuration
REQ-024 Macro RAS_STATS_EN: when defined, the block SHALL add 32-bit outputs ras_ovf_cnt_o (REQ-017 events) and ras_unf_cnt_o (pop at cnt==0), each wrapping at 2^32 and cleared by reset; when undefined these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-025 Icode constants (ICALL=4'h8, IRET=4'h9, IJXX=4'h7, IHALT=4'h0) SHALL come from the shared y86 constants package/include, not be redefined locally.
REQ-026 Storage SHALL be a sub-module ras_regfile (DEPTH x WIDTH, one synchronous write port, one asynchronous read port); pointer/count logic stays in return_addr_stack.

Verification
REQ-027 Reset, then CALL valP=0x100 fetched with f_adv_i=1 -> next cycle f_ret_valid_o=1, f_ret_pred_o=0x100; RET fetched -> valid=0.
REQ-028 Nine CALLs valP=0x10..0x90 with DEPTH=8 -> cnt=8; eight RETs yield 0x90..0x20 in order; ninth RET -> valid=0, ras_unf_cnt_o=1 (ras_ovf_cnt_o=1).
REQ-029 CALL 0x40 committed at W, then wrong-path CALL 0x80 fetched, then flush_i -> f_ret_pred_o=0x40, cnt=1.
REQ-030 CALL fetched with f_adv_i=0 (stall) for 3 cycles then 1 -> exactly one push.
REQ-031 flush_i asserted same cycle as a fetched CALL and a committing RET (ccnt=2) -> no push, cnt=ccnt=1.
REQ-032 rst_i asserted mid-sequence with cnt=5 -> next cycle valid=0, pred=0, all counters 0.
